xorexec_pwr_seq: RTL and testbench
==================================

# xorexec_pwr_seq

Power-sequencing controller for the gated xorexec execution domain. It watches input-FIFO occupancy and exec-unit idleness, powers the domain down after a programmable idle window, and wakes it when new work arrives. Wake-up runs the full isolate/save/off/up/reset/restore/de-isolate sequence. It sits at the top level beside the FIFOs and drives the domain's switch, isolation, retention and power-on-reset controls.

## Interface
- IDLE_CNT, 16: consecutive qualifying idle cycles in RUN before power-down starts; must be ≥1.
- ISO_DLY, 2: cycles spent in ISO and in UNISO; must be ≥1.
- RST_CNT, 4: cycles pwron_reset is held in RST; must be ≥1.
- UP_TMO, 8: maximum cycles spent in UP waiting for pwr_ack; must be ≥1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- pwr_en  in  1  1 = power gating permitted; 0 = forces or keeps the domain on.
- ififo_rdy  in  1  input FIFO holds data.
- exec_idle  in  1  exec unit has no transaction in flight.
- pwr_ack  in  1  power switch reports the domain rail is good.
- pwr_down  out  1  1 = domain switch off.
- iso_enable  out  1  clamp the domain outputs.
- save  out  1  one-cycle retention save strobe.
- restore  out  1  one-cycle retention restore strobe.
- pwron_reset  out  1  reset to the exec unit after power-up.
- exec_hold  out  1  blocks exec pops; 1 in every state except RUN.
- pwr_err  out  1  sticky flag; set on UP timeout.
- state  out  3  current state encoding, for debug.

## Operation
- State encodings: RUN=0, ISO=1, SAVE=2, OFF=3, UP=4, RST=5, RESTORE=6, UNISO=7.
- All outputs are Moore outputs decoded from the registered state. pwr_err is a separate register.
- One shared down-counter, cnt, sized to $clog2(max param + 1) bits. It is loaded on each state entry and has no wrap-around.
- RUN: idle condition is pwr_en & exec_idle & !ififo_rdy.
  - While the condition holds, cnt increments; any cycle it fails clears cnt to 0.
  - When the condition holds and cnt == IDLE_CNT-1, go to ISO. This means IDLE_CNT consecutive idle cycles.
- ISO: iso_enable=1. Stay ISO_DLY cycles, then go to SAVE.
- SAVE: save=1 for exactly 1 cycle, then go to OFF.
- OFF: pwr_down=1. Leave when ififo_rdy | !pwr_en is sampled high; go to UP. OFF lasts at least 1 cycle.
- UP: pwr_down=0.
  - If pwr_ack is sampled 1, go to RST.
  - After UP_TMO cycles without pwr_ack, set pwr_err=1 and go to RST anyway.
- RST: pwron_reset=1 for RST_CNT cycles, then go to RESTORE.
- RESTORE: restore=1 for exactly 1 cycle, then go to UNISO.
- UNISO: iso_enable stays 1 for ISO_DLY cycles, then go to RUN.
- iso_enable=1 in every state except RUN.
- pwr_err clears only on rst.
- Once ISO is entered, the sequence always runs through OFF. A wake request (ififo_rdy or !pwr_en) arriving during ISO or SAVE does not abort the sequence; it is acted on in the first OFF cycle.
- pwr_en=0 in RUN: cnt is held at 0 and the block never leaves RUN.
- pwr_ack is ignored outside UP.

## Timing
- Reset: on any clk edge with rst=0, the block enters RUN.
  - cnt=0, pwr_err=0.
  - Outputs: pwr_down=0, iso_enable=0, save=0, restore=0, pwron_reset=0, exec_hold=0, state=0.
  - Reset applied mid-sequence, including OFF, returns the block to RUN in the same cycle. No save or restore strobe is emitted.
- Power-down latency: edge k is the first edge sampling the idle condition. ISO is entered at edge k+IDLE_CNT-1.
  - pwr_down rises ISO_DLY+1 cycles after ISO entry.
- Wake latency: edge w samples ififo_rdy in OFF, and pwr_ack is already 1.
  - UP for 1 cycle, RST for RST_CNT, RESTORE for 1, UNISO for ISO_DLY.
  - RUN is entered at edge w+2+RST_CNT+ISO_DLY. With defaults this is w+8; exec_hold and iso_enable fall together.
- save and restore are never high in the same cycle, nor high together with pwr_down.

## Test plan
- Idle entry: pwr_en=1, exec_idle=1, ififo_rdy=0 held.
  - ISO after 16 cycles, SAVE 2 cycles later (1-cycle save pulse), pwr_down=1 next cycle.
- Idle interrupted: condition holds 15 cycles, drops 1 cycle, then holds again.
  - No ISO until 16 further consecutive idle cycles.
- Wake: in OFF, raise ififo_rdy with pwr_ack=1.
  - State sequence 4,5×4,6,7×2,0. pwron_reset high 4 cycles, restore 1 cycle. exec_hold=0 exactly 8 cycles after the sampling edge.
- Ack timeout: in UP, hold pwr_ack=0.
  - After 8 cycles, pwr_err=1 and RST is entered. pwr_err stays 1 through RUN until rst=0.
- Late wake: assert ififo_rdy during ISO.
  - Sequence still passes SAVE then OFF (pwr_down=1 for exactly 1 cycle), then UP.
- Reset mid-sequence: drive rst=0 for 1 cycle while in RST.
  - state=0 and all outputs 0 on the next cycle. pwr_err=0 and no restore pulse.

Source files
------------

// File: rtl/xorexec_pwr_seq.sv
// Power-sequencing controller for the gated xorexec execution domain.
// Counts idle cycles in RUN, then walks isolate/save/off. On wake it walks
// up/reset/restore/de-isolate. All outputs are decoded from the registered state.
module xorexec_pwr_seq #(
    parameter int IDLE_CNT = 16,
    parameter int ISO_DLY  = 2,
    parameter int RST_CNT  = 4,
    parameter int UP_TMO   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwr_en,
    input  logic       ififo_rdy,
    input  logic       exec_idle,
    input  logic       pwr_ack,
    output logic       pwr_down,
    output logic       iso_enable,
    output logic       save,
    output logic       restore,
    output logic       pwron_reset,
    output logic       exec_hold,
    output logic       pwr_err,
    output logic [2:0] state
);

    localparam int MAX_A = (IDLE_CNT > ISO_DLY) ? IDLE_CNT : ISO_DLY;
    localparam int MAX_B = (RST_CNT > UP_TMO) ? RST_CNT : UP_TMO;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P + 1);

    // Last value of the shared counter before each timed state exits
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CNT - 1);
    localparam logic [CW-1:0] ISO_LAST  = CW'(ISO_DLY - 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CNT - 1);
    localparam logic [CW-1:0] UP_LAST   = CW'(UP_TMO - 1);

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_ISO     = 3'd1,
        S_SAVE    = 3'd2,
        S_OFF     = 3'd3,
        S_UP      = 3'd4,
        S_RST     = 3'd5,
        S_RESTORE = 3'd6,
        S_UNISO   = 3'd7
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          pwr_err_reg, pwr_err_next;
    logic          idle_cond;
    logic          wake;

    assign idle_cond = pwr_en & exec_idle & ~ififo_rdy;
    assign wake      = ififo_rdy | ~pwr_en;

    // State, shared counter and sticky error register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_RUN;
            cnt_reg     <= '0;
            pwr_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pwr_err_reg <= pwr_err_next;
        end
    end

    // Next-state logic; the counter counts up in RUN and down in the timed states
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pwr_err_next = pwr_err_reg;
        case (state_reg)
            S_RUN: begin
                if (idle_cond) begin
                    if (cnt_reg == IDLE_LAST) begin
                        state_next = S_ISO;
                        cnt_next   = ISO_LAST;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            S_ISO: begin
                if (cnt_reg == '0) begin
                    state_next = S_SAVE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_SAVE: begin
                state_next = S_OFF;
                cnt_next   = '0;
            end
            S_OFF: begin
                if (wake) begin
                    state_next = S_UP;
                    cnt_next   = UP_LAST;
                end
            end
            S_UP: begin
                if (pwr_ack) begin
                    state_next = S_RST;
                    cnt_next   = RST_LAST;
                end else if (cnt_reg == '0) begin
                    // Rail never reported good; proceed anyway and flag it
                    state_next   = S_RST;
                    cnt_next     = RST_LAST;
                    pwr_err_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_RST: begin
                if (cnt_reg == '0) begin
                    state_next = S_RESTORE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            S_RESTORE: begin
                state_next = S_UNISO;
                cnt_next   = ISO_LAST;
            end
            S_UNISO: begin
                if (cnt_reg == '0) begin
                    state_next = S_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = S_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    assign pwr_down    = (state_reg == S_OFF);
    assign iso_enable  = (state_reg != S_RUN);
    assign exec_hold   = (state_reg != S_RUN);
    assign save        = (state_reg == S_SAVE);
    assign restore     = (state_reg == S_RESTORE);
    assign pwron_reset = (state_reg == S_RST);
    assign pwr_err     = pwr_err_reg;
    assign state       = state_reg;

endmodule

// File: tb/tb_xorexec_pwr_seq.sv
// Directed testbench for xorexec_pwr_seq with default parameters.
module tb_xorexec_pwr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwr_en = 1'b1;
    logic       ififo_rdy = 1'b0;
    logic       exec_idle = 1'b0;
    logic       pwr_ack = 1'b0;
    logic       pwr_down, iso_enable, save, restore, pwron_reset, exec_hold, pwr_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    xorexec_pwr_seq dut (
        .clk(clk), .rst(rst), .pwr_en(pwr_en), .ififo_rdy(ififo_rdy),
        .exec_idle(exec_idle), .pwr_ack(pwr_ack), .pwr_down(pwr_down),
        .iso_enable(iso_enable), .save(save), .restore(restore),
        .pwron_reset(pwron_reset), .exec_hold(exec_hold), .pwr_err(pwr_err),
        .state(state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if ({pwr_down, iso_enable, save, restore, pwron_reset, exec_hold, pwr_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000",
                     {pwr_down, iso_enable, save, restore, pwron_reset, exec_hold, pwr_err});
        end
        rst = 1'b1;
        $display("test_reset done: state=%0d", state);
    endtask

    task automatic test_idle_entry();
        exec_idle = 1'b0;
        tick();
        exec_idle = 1'b1;
        ififo_rdy = 1'b0;
        pwr_en    = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (state !== 3'd0 || exec_hold !== 1'b0) begin
                errors++;
                $display("FAIL idle_count_run tick %0d got state %0d hold %b want 0 0", i, state, exec_hold);
            end
        end
        tick();
        checks++;
        if (state !== 3'd1 || iso_enable !== 1'b1 || exec_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_iso_entry got state %0d iso %b hold %b want 1 1 1", state, iso_enable, exec_hold);
        end
        tick();
        checks++;
        if (state !== 3'd1 || save !== 1'b0) begin
            errors++;
            $display("FAIL idle_iso_hold got state %0d save %b want 1 0", state, save);
        end
        tick();
        checks++;
        if (state !== 3'd2 || save !== 1'b1 || pwr_down !== 1'b0) begin
            errors++;
            $display("FAIL idle_save got state %0d save %b pwr_down %b want 2 1 0", state, save, pwr_down);
        end
        tick();
        checks++;
        if (state !== 3'd3 || save !== 1'b0 || pwr_down !== 1'b1) begin
            errors++;
            $display("FAIL idle_off got state %0d save %b pwr_down %b want 3 0 1", state, save, pwr_down);
        end
        $display("test_idle_entry done: state=%0d pwr_down=%b", state, pwr_down);
    endtask

    task automatic test_wake();
        int exp_seq[9] = '{4, 5, 5, 5, 5, 6, 7, 7, 0};
        int rst_cycles = 0;
        int rst_cycles_exp = 4;
        int restore_cycles = 0;
        pwr_ack   = 1'b1;
        ififo_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 1) ififo_rdy = 1'b0;
            if (i == 1) exec_idle = 1'b0;
            checks++;
            if (state !== 3'(exp_seq[i])) begin
                errors++;
                $display("FAIL wake_seq step %0d got %0d want %0d", i, state, exp_seq[i]);
            end
            if (pwron_reset === 1'b1) rst_cycles++;
            if (restore === 1'b1) restore_cycles++;
            checks++;
            if ((save & restore) !== 1'b0 || (restore & pwr_down) !== 1'b0) begin
                errors++;
                $display("FAIL wake_strobe_overlap step %0d save %b restore %b pwr_down %b", i, save, restore, pwr_down);
            end
            checks++;
            if (exec_hold !== (i < 8)) begin
                errors++;
                $display("FAIL wake_exec_hold step %0d got %b want %b", i, exec_hold, (i < 8));
            end
        end
        checks++;
        if (rst_cycles != rst_cycles_exp) begin
            errors++;
            $display("FAIL wake_pwron_reset_len got %0d want 4", rst_cycles);
        end
        checks++;
        if (restore_cycles != 1) begin
            errors++;
            $display("FAIL wake_restore_len got %0d want 1", restore_cycles);
        end
        checks++;
        if (iso_enable !== 1'b0 || pwr_err !== 1'b0) begin
            errors++;
            $display("FAIL wake_run_outputs iso %b err %b want 0 0", iso_enable, pwr_err);
        end
        $display("test_wake done: state=%0d", state);
    endtask

    task automatic test_idle_interrupted();
        exec_idle = 1'b1;
        ififo_rdy = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL intr_first15 got %0d want 0", state);
        end
        exec_idle = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL intr_drop got %0d want 0", state);
        end
        exec_idle = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (state !== 3'd0) begin
                errors++;
                $display("FAIL intr_recount tick %0d got %0d want 0", i, state);
            end
        end
        tick();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL intr_iso got %0d want 1", state);
        end
        tick();
        tick();
        tick();
        checks++;
        if (state !== 3'd3) begin
            errors++;
            $display("FAIL intr_off got %0d want 3", state);
        end
        $display("test_idle_interrupted done: state=%0d", state);
    endtask

    task automatic test_ack_timeout();
        pwr_ack   = 1'b0;
        ififo_rdy = 1'b1;
        tick();
        checks++;
        if (state !== 3'd4 || pwr_down !== 1'b0) begin
            errors++;
            $display("FAIL tmo_up_entry got state %0d pwr_down %b want 4 0", state, pwr_down);
        end
        ififo_rdy = 1'b0;
        exec_idle = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if (state !== 3'd4 || pwr_err !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait tick %0d got state %0d err %b want 4 0", i, state, pwr_err);
            end
        end
        tick();
        checks++;
        if (state !== 3'd5 || pwr_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_expire got state %0d err %b want 5 1", state, pwr_err);
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (state !== 3'd0 || pwr_err !== 1'b1) begin
            errors++;
            $display("FAIL tmo_sticky_run got state %0d err %b want 0 1", state, pwr_err);
        end
        $display("test_ack_timeout done: state=%0d pwr_err=%b", state, pwr_err);
    endtask

    task automatic test_pwr_en_off();
        int left_run = 0;
        pwr_en    = 1'b0;
        exec_idle = 1'b1;
        ififo_rdy = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (state !== 3'd0) left_run++;
        end
        checks++;
        if (left_run != 0) begin
            errors++;
            $display("FAIL pwr_en_off_stays_run got %0d non-RUN cycles want 0", left_run);
        end
        pwr_en    = 1'b1;
        exec_idle = 1'b0;
        tick();
        $display("test_pwr_en_off done: state=%0d", state);
    endtask

    task automatic test_late_wake();
        exec_idle = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL late_iso got %0d want 1", state);
        end
        ififo_rdy = 1'b1;
        pwr_ack   = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1) begin
            errors++;
            $display("FAIL late_iso_no_abort got %0d want 1", state);
        end
        tick();
        checks++;
        if (state !== 3'd2 || save !== 1'b1) begin
            errors++;
            $display("FAIL late_save got state %0d save %b want 2 1", state, save);
        end
        tick();
        checks++;
        if (state !== 3'd3 || pwr_down !== 1'b1) begin
            errors++;
            $display("FAIL late_off got state %0d pwr_down %b want 3 1", state, pwr_down);
        end
        tick();
        checks++;
        if (state !== 3'd4 || pwr_down !== 1'b0) begin
            errors++;
            $display("FAIL late_up got state %0d pwr_down %b want 4 0", state, pwr_down);
        end
        ififo_rdy = 1'b0;
        exec_idle = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (state !== 3'd0 || pwr_err !== 1'b1) begin
            errors++;
            $display("FAIL late_back_run got state %0d err %b want 0 1", state, pwr_err);
        end
        $display("test_late_wake done: state=%0d", state);
    endtask

    task automatic test_reset_mid();
        int restore_seen = 0;
        exec_idle = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        ififo_rdy = 1'b1;
        pwr_ack   = 1'b1;
        tick();
        tick();
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL rstmid_in_rst got %0d want 5", state);
        end
        rst = 1'b0;
        tick();
        rst       = 1'b1;
        ififo_rdy = 1'b0;
        exec_idle = 1'b0;
        checks++;
        if (state !== 3'd0 ||
            {pwr_down, iso_enable, save, restore, pwron_reset, exec_hold, pwr_err} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_outputs got state %0d outs %b want 0 0000000", state,
                     {pwr_down, iso_enable, save, restore, pwron_reset, exec_hold, pwr_err});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (restore === 1'b1 || state !== 3'd0) restore_seen++;
        end
        checks++;
        if (restore_seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_restore got %0d bad cycles want 0", restore_seen);
        end
        $display("test_reset_mid done: state=%0d", state);
    endtask

    initial begin
        test_reset();
        test_idle_entry();
        test_wake();
        test_idle_interrupted();
        test_ack_timeout();
        test_pwr_en_off();
        test_late_wake();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
